// File: rtl/wb_pkg.sv
// Writeback opcode table and entry type shared by every pipeline stage.
// decode_wb gives the {sel, we, rd} decode for the default 32-bit instruction word.
package wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_IW = 32;
    localparam int WB_RW = 5;

    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_LI    = 4'h2;
    localparam logic [3:0] OP_ADDU  = 4'h3;
    localparam logic [3:0] OP_ADDIU = 4'h4;
    localparam logic [3:0] OP_SLL   = 4'h5;
    localparam logic [3:0] OP_MUL   = 4'h6;
    localparam logic [3:0] OP_MULI  = 4'h7;
    localparam logic [3:0] OP_SW    = 4'h8;

    typedef struct packed {
        logic             valid;
        logic [WB_DW-1:0] mem;
        logic [WB_DW-1:0] alu;
        logic             sel;
        logic             we;
        logic [WB_RW-1:0] rd;
    } wb_entry_t;

    function automatic logic op_writes(input logic [3:0] op);
        case (op)
            OP_LW, OP_LI, OP_ADDU, OP_ADDIU, OP_SLL, OP_MUL, OP_MULI: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    // Payload fields stay zero; the stage fills them in at capture.
    function automatic wb_entry_t decode_wb(input logic [WB_IW-1:0] ir);
        wb_entry_t e;
        e       = '0;
        e.sel   = (ir[WB_IW-1 -: 4] != OP_LW);
        e.we    = op_writes(ir[WB_IW-1 -: 4]);
        e.rd    = e.we ? ir[WB_IW-5 -: WB_RW] : '1;
        return e;
    endfunction

endpackage

// File: rtl/wb_decode.sv
// Combinational opcode -> {sel, we, rd} writeback decoder.
// Unknown opcodes become non-writing ALU ops.
module wb_decode
    import wb_pkg::*;
#(
    parameter int IW = 32,
    parameter int RW = 5
) (
    input  logic [IW-1:0] ir,
    output logic          sel,
    output logic          we,
    output logic [RW-1:0] rd
);

    logic [3:0] op;
    logic       unused_ir;

    assign op        = ir[IW-1 -: 4];
    assign unused_ir = ^ir[IW-5-RW:0];

    assign sel = (op != OP_LW);
    assign we  = op_writes(op);
    assign rd  = we ? ir[IW-5 -: RW] : '1;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage: head register H plus skid register S forming a 2-deep FIFO.
// in_ready depends only on registered state, so WB backpressure never reaches MEM combinationally.
module mem_wb_skid_stage
    import wb_pkg::*;
#(
    parameter int DW = 32,
    parameter int IW = 32,
    parameter int RW = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] mem_data_i,
    input  logic [DW-1:0] alu_data_i,
    input  logic [IW-1:0] ir_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] mem_data_o,
    output logic [DW-1:0] alu_data_o,
    output logic          wb_sel_o,
    output logic          reg_we_o,
    output logic [RW-1:0] reg_num_o,
    output logic [DW-1:0] wb_data_o,
    output logic [1:0]    occ_o
);

    typedef struct packed {
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic          sel;
        logic          we;
        logic [RW-1:0] rd;
    } pay_t;

    logic          dec_sel;
    logic          dec_we;
    logic [RW-1:0] dec_rd;
    pay_t          in_pay;

    logic vld_h_p1;
    logic vld_s_p1;
    pay_t pay_h_p1;
    pay_t pay_s_p1;

    logic accept;
    logic pop;

    wb_decode #(
        .IW (IW),
        .RW (RW)
    ) u_decode (
        .ir  (ir_i),
        .sel (dec_sel),
        .we  (dec_we),
        .rd  (dec_rd)
    );

    assign in_pay = '{mem: mem_data_i, alu: alu_data_i, sel: dec_sel, we: dec_we, rd: dec_rd};

    assign in_ready_o = !vld_s_p1;
    assign accept     = in_valid_i && in_ready_o;
    assign pop        = vld_h_p1 && out_ready_i;

    // ---- capture stage: occupancy control (S valid implies H valid) ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_h_p1 <= 1'b0;
            vld_s_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_h_p1 <= 1'b0;
            vld_s_p1 <= 1'b0;
        end else if (vld_s_p1) begin
            vld_h_p1 <= 1'b1;
            vld_s_p1 <= !pop;
        end else begin
            vld_h_p1 <= accept || (vld_h_p1 && !pop);
            vld_s_p1 <= accept && vld_h_p1 && !pop;
        end
    end

    // Payload is unqualified storage; stale contents are masked by the valid bits.
    always_ff @(posedge clk_i) begin
        if (vld_s_p1) begin
            if (pop) pay_h_p1 <= pay_s_p1;
        end else if (accept) begin
            if (!vld_h_p1 || pop) pay_h_p1 <= in_pay;
            else                  pay_s_p1 <= in_pay;
        end
    end

    // ---- output stage: head entry, forced to reset values when empty ----
    assign out_valid_o = vld_h_p1;
    assign mem_data_o  = vld_h_p1 ? pay_h_p1.mem : '0;
    assign alu_data_o  = vld_h_p1 ? pay_h_p1.alu : '0;
    assign wb_sel_o    = vld_h_p1 ? pay_h_p1.sel : 1'b1;
    assign reg_we_o    = vld_h_p1 && pay_h_p1.we;
    assign reg_num_o   = vld_h_p1 ? pay_h_p1.rd : '1;
    assign wb_data_o   = !vld_h_p1     ? '0 :
                         pay_h_p1.sel  ? pay_h_p1.alu : pay_h_p1.mem;
    assign occ_o       = {1'b0, vld_h_p1} + {1'b0, vld_s_p1};

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed + randomized bench for mem_wb_skid_stage against a queue-based FIFO model.
module tb_mem_wb_skid_stage;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_d;
    logic [31:0] alu_d;
    logic [31:0] ir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mem_o;
    logic [31:0] alu_o;
    logic        wb_sel;
    logic        reg_we;
    logic [4:0]  reg_num;
    logic [31:0] wb_data;
    logic [1:0]  occ;

    mem_wb_skid_stage #(.DW(32), .IW(32), .RW(5)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mem_data_i  (mem_d),
        .alu_data_i  (alu_d),
        .ir_i        (ir),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .mem_data_o  (mem_o),
        .alu_data_o  (alu_o),
        .wb_sel_o    (wb_sel),
        .reg_we_o    (reg_we),
        .reg_num_o   (reg_num),
        .wb_data_o   (wb_data),
        .occ_o       (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] ir;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_ir(input logic [3:0] op, input logic [4:0] rd);
        logic [22:0] r;
        r = 23'($urandom);
        return {op, rd, r};
    endfunction

    // Expected head view derived from the opcode rules, independent of the RTL encoding.
    task automatic check_outputs(input string tag);
        logic        e_v, e_sel, e_we;
        logic [31:0] e_mem, e_alu, e_wb;
        logic [4:0]  e_rd;
        logic [3:0]  op;
        if (q.size() == 0) begin
            e_v = 0; e_mem = 0; e_alu = 0; e_sel = 1; e_we = 0; e_rd = 5'h1F; e_wb = 0;
        end else begin
            op    = q[0].ir[31:28];
            e_v   = 1;
            e_mem = q[0].mem;
            e_alu = q[0].alu;
            e_sel = (op != OP_LW);
            e_we  = op inside {OP_LW, OP_LI, OP_ADDU, OP_ADDIU, OP_SLL, OP_MUL, OP_MULI};
            e_rd  = e_we ? q[0].ir[27:23] : 5'h1F;
            e_wb  = e_sel ? e_alu : e_mem;
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_v));
        chk({tag, ".mem"},       64'(mem_o),     64'(e_mem));
        chk({tag, ".alu"},       64'(alu_o),     64'(e_alu));
        chk({tag, ".sel"},       64'(wb_sel),    64'(e_sel));
        chk({tag, ".we"},        64'(reg_we),    64'(e_we));
        chk({tag, ".rd"},        64'(reg_num),   64'(e_rd));
        chk({tag, ".wb_data"},   64'(wb_data),   64'(e_wb));
        chk({tag, ".occ"},       64'(occ),       64'(q.size()));
    endtask

    task automatic step(input string tag, input logic iv, input logic ordy, input logic fl,
                        input logic [31:0] m, input logic [31:0] a, input logic [31:0] i);
        logic acc, pp;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        mem_d     = m;
        alu_d     = a;
        ir        = i;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        acc = iv && (q.size() < 2);
        pp  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (!rst_n || fl) begin
            q.delete();
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back('{mem: m, alu: a, ir: i});
        end
        #1;
        check_outputs(tag);
    endtask

    logic [3:0] ops [10];

    initial begin
        ops = '{OP_LW, OP_LI, OP_ADDU, OP_ADDIU, OP_SLL, OP_MUL, OP_MULI, OP_SW, 4'hF, 4'h0};
        rst_n = 0; flush = 0; in_valid = 1; out_ready = 1;
        mem_d = 32'hDEAD_BEEF; alu_d = 32'hCAFE_F00D; ir = mk_ir(OP_LW, 5'd9);

        // Reset held with live inputs
        step("rst0", 1, 1, 0, 32'h1111_1111, 32'h2222_2222, mk_ir(OP_LW, 5'd4));
        step("rst1", 1, 0, 0, 32'h3333_3333, 32'h4444_4444, mk_ir(OP_ADDU, 5'd5));
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        chk("rst.reg_num",  64'(reg_num),  64'(5'h1F));

        // Streaming LW rd=3 then ADDU rd=7
        rst_n = 1;
        step("lw", 1, 1, 0, 32'hA000_0001, 32'hB000_0001, mk_ir(OP_LW, 5'd3));
        chk("lw.rd_explicit",  64'(reg_num), 64'(3));
        chk("lw.wb_is_mem",    64'(wb_data), 64'(32'hA000_0001));
        step("addu", 1, 1, 0, 32'hA000_0002, 32'hB000_0002, mk_ir(OP_ADDU, 5'd7));
        chk("addu.rd_explicit", 64'(reg_num), 64'(7));
        chk("addu.wb_is_alu",   64'(wb_data), 64'(32'hB000_0002));
        step("drain0", 0, 1, 0, 0, 0, 0);

        // Stall: A, B accepted, C held off
        step("stallA", 1, 0, 0, 32'h0A0A_0A0A, 32'h1A1A_1A1A, mk_ir(OP_LI, 5'd10));
        step("stallB", 1, 0, 0, 32'h0B0B_0B0B, 32'h1B1B_1B1B, mk_ir(OP_LW, 5'd11));
        chk("stall.occ2",     64'(occ),      64'(2));
        chk("stall.in_ready", 64'(in_ready), 64'(0));
        step("stallC", 1, 0, 0, 32'h0C0C_0C0C, 32'h1C1C_1C1C, mk_ir(OP_MUL, 5'd12));
        step("rel0", 1, 1, 0, 32'h0C0C_0C0C, 32'h1C1C_1C1C, mk_ir(OP_MUL, 5'd12));
        step("rel1", 0, 1, 0, 0, 0, 0);
        step("rel2", 0, 1, 0, 0, 0, 0);
        step("rel3", 0, 1, 0, 0, 0, 0);

        // Non-writing opcode
        step("sw", 1, 0, 0, 32'h5555_0000, 32'h6666_0000, mk_ir(OP_SW, 5'd2));
        chk("sw.valid", 64'(out_valid), 64'(1));
        chk("sw.we",    64'(reg_we),    64'(0));
        chk("sw.rd",    64'(reg_num),   64'(5'h1F));
        step("swpop", 0, 1, 0, 0, 0, 0);

        // Flush while full with a concurrent beat
        step("flA", 1, 0, 0, 32'h7000_0001, 32'h8000_0001, mk_ir(OP_ADDIU, 5'd13));
        step("flB", 1, 0, 0, 32'h7000_0002, 32'h8000_0002, mk_ir(OP_SLL, 5'd14));
        step("flush", 1, 1, 1, 32'h7000_0003, 32'h8000_0003, mk_ir(OP_LW, 5'd15));
        chk("flush.occ0",  64'(occ),       64'(0));
        chk("flush.valid", 64'(out_valid), 64'(0));
        step("postfl", 0, 1, 0, 0, 0, 0);

        // Async reset mid-cycle while full
        step("arA", 1, 0, 0, 32'h9000_0001, 32'h9100_0001, mk_ir(OP_MULI, 5'd16));
        step("arB", 1, 0, 0, 32'h9000_0002, 32'h9100_0002, mk_ir(OP_LW, 5'd17));
        #2 rst_n = 0;
        #1;
        q.delete();
        chk("areset.valid",    64'(out_valid), 64'(0));
        chk("areset.occ",      64'(occ),       64'(0));
        chk("areset.in_ready", 64'(in_ready),  64'(1));
        check_outputs("areset");
        step("arHold", 1, 1, 0, 32'h9000_0003, 32'h9100_0003, mk_ir(OP_LI, 5'd18));
        rst_n = 1;
        step("arResume", 1, 1, 0, 32'h9000_0004, 32'h9100_0004, mk_ir(OP_LI, 5'd19));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0), $urandom, $urandom,
                 mk_ir(ops[$urandom_range(0, 9)], 5'($urandom)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
